divider32: RTL and testbench

Iterative 32-bit signed/unsigned divider for the datapath. It takes a dividend and divisor through a start/done handshake and produces quotient and remainder after a fixed number of cycles. It sits directly upstream of the 32-bit 2:1 result selector, which picks either the quotient or the remainder for write-back. Results are registered and held stable until the next accepted start.

---
 rtl/divider32_if.sv | 23 ++
 rtl/divider32.sv | 135 +++++++++++++
 tb/tb_divider32.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/divider32_if.sv
// Handshake and result bundle between the datapath and the iterative divider.
// The master drives requests and operands; the slave is the divider itself.
interface divider32_if;
  logic        iStart;
  logic        iSigned;
  logic [31:0] iDividend;
  logic [31:0] iDivisor;
  logic [31:0] oQuotient;
  logic [31:0] oRemainder;
  logic        oBusy;
  logic        oDone;
  logic        oDivZero;

  modport master (
    output iStart, iSigned, iDividend, iDivisor,
    input  oQuotient, oRemainder, oBusy, oDone, oDivZero
  );

  modport slave (
    input  iStart, iSigned, iDividend, iDivisor,
    output oQuotient, oRemainder, oBusy, oDone, oDivZero
  );
endinterface

// File: rtl/divider32.sv
// Iterative 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Results are registered and held until the next accepted start.
module divider32 (
  input  logic      iClk,
  input  logic      iRst,
  divider32_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFin} stateT;

  stateT       stateQ, stateD;
  logic [31:0] divisorQ, divisorD;
  logic [32:0] remQ, remD;
  logic [31:0] quoQ, quoD;
  logic [5:0]  cntQ, cntD;
  logic        quoNegQ, quoNegD;
  logic        remNegQ, remNegD;
  logic        zeroFlagQ, zeroFlagD;
  logic [31:0] quotientQ, quotientD;
  logic [31:0] remainderQ, remainderD;
  logic        busyQ, busyD;
  logic        doneQ, doneD;
  logic        divZeroQ, divZeroD;

  logic        dvdNeg, dvsNeg;
  logic [33:0] shifted, trial;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      stateQ     <= StIdle;
      divisorQ   <= '0;
      remQ       <= '0;
      quoQ       <= '0;
      cntQ       <= '0;
      quoNegQ    <= 1'b0;
      remNegQ    <= 1'b0;
      zeroFlagQ  <= 1'b0;
      quotientQ  <= '0;
      remainderQ <= '0;
      busyQ      <= 1'b0;
      doneQ      <= 1'b0;
      divZeroQ   <= 1'b0;
    end else begin
      stateQ     <= stateD;
      divisorQ   <= divisorD;
      remQ       <= remD;
      quoQ       <= quoD;
      cntQ       <= cntD;
      quoNegQ    <= quoNegD;
      remNegQ    <= remNegD;
      zeroFlagQ  <= zeroFlagD;
      quotientQ  <= quotientD;
      remainderQ <= remainderD;
      busyQ      <= busyD;
      doneQ      <= doneD;
      divZeroQ   <= divZeroD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    divisorD   = divisorQ;
    remD       = remQ;
    quoD       = quoQ;
    cntD       = cntQ;
    quoNegD    = quoNegQ;
    remNegD    = remNegQ;
    zeroFlagD  = zeroFlagQ;
    quotientD  = quotientQ;
    remainderD = remainderQ;
    busyD      = busyQ;
    doneD      = 1'b0;
    divZeroD   = divZeroQ;

    dvdNeg  = bus.iSigned & bus.iDividend[31];
    dvsNeg  = bus.iSigned & bus.iDivisor[31];
    shifted = {remQ, quoQ[31]};
    trial   = shifted - {2'b00, divisorQ};

    case (stateQ)
      StIdle: begin
        if (bus.iStart) begin
          busyD = 1'b1;
          if (bus.iDivisor == '0) begin
            // Quotient register parks the raw dividend for the zero-divisor result.
            zeroFlagD = 1'b1;
            quoD      = bus.iDividend;
            stateD    = StFin;
          end else begin
            zeroFlagD = 1'b0;
            quoD      = dvdNeg ? -bus.iDividend : bus.iDividend;
            divisorD  = dvsNeg ? -bus.iDivisor : bus.iDivisor;
            remD      = '0;
            cntD      = '0;
            quoNegD   = dvdNeg ^ dvsNeg;
            remNegD   = dvdNeg;
            stateD    = StCalc;
          end
        end
      end

      StCalc: begin
        remD = trial[33] ? shifted[32:0] : trial[32:0];
        quoD = {quoQ[30:0], ~trial[33]};
        cntD = cntQ + 6'd1;
        if (cntQ == 6'd31) begin
          stateD = StFin;
        end
      end

      StFin: begin
        busyD    = 1'b0;
        doneD    = 1'b1;
        divZeroD = zeroFlagQ;
        if (zeroFlagQ) begin
          quotientD  = '1;
          remainderD = quoQ;
        end else begin
          quotientD  = quoNegQ ? -quoQ : quoQ;
          remainderD = remNegQ ? -remQ[31:0] : remQ[31:0];
        end
        stateD = StIdle;
      end

      default: stateD = StIdle;
    endcase
  end

  assign bus.oQuotient  = quotientQ;
  assign bus.oRemainder = remainderQ;
  assign bus.oBusy      = busyQ;
  assign bus.oDone      = doneQ;
  assign bus.oDivZero   = divZeroQ;

endmodule

// File: tb/tb_divider32.sv
// Self-checking bench for divider32: per-cycle compare against an arithmetic model,
// plus directed cases with hand-computed results and randomized operands.
module tb_divider32;

  logic iClk = 1'b0;
  logic iRst;

  always #5 iClk = ~iClk;

  divider32_if bus ();

  divider32 dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result from plain 64-bit arithmetic (truncating division).
  function automatic void refDiv(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic dz);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q  = 32'hFFFFFFFF;
      r  = a;
      dz = 1'b1;
      return;
    end
    sa = s ? longint'($signed(a)) : longint'({32'd0, a});
    sb = s ? longint'($signed(b)) : longint'({32'd0, b});
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[31:0];
    r  = lr[31:0];
    dz = 1'b0;
  endfunction

  // Behavioural model: result appears a fixed number of edges after acceptance.
  logic [31:0] mQ = '0, mR = '0, pQ = '0, pR = '0;
  logic        mBusy = 1'b0, mDone = 1'b0, mDz = 1'b0, pDz = 1'b0;
  int          mLeft = 0;
  bit          mValid = 1'b0;

  always @(posedge iClk) begin
    if (iRst) begin
      mQ = '0; mR = '0; mBusy = 1'b0; mDone = 1'b0; mDz = 1'b0; mLeft = 0;
      mValid = 1'b1;
    end else if (mLeft > 0) begin
      mLeft--;
      if (mLeft == 0) begin
        mQ = pQ; mR = pR; mDz = pDz; mDone = 1'b1; mBusy = 1'b0;
      end
    end else begin
      mDone = 1'b0;
      if (bus.iStart) begin
        refDiv(bus.iDividend, bus.iDivisor, bus.iSigned, pQ, pR, pDz);
        mLeft = pDz ? 1 : 33;
        mBusy = 1'b1;
      end
    end
  end

  always @(negedge iClk) begin
    if (mValid) begin
      check("cyc busy",      32'(bus.oBusy),    32'(mBusy));
      check("cyc done",      32'(bus.oDone),    32'(mDone));
      check("cyc divzero",   32'(bus.oDivZero), 32'(mDz));
      check("cyc quotient",  bus.oQuotient,     mQ);
      check("cyc remainder", bus.oRemainder,    mR);
    end
  end

  // Caller sits at a negedge; returns at the negedge where oDone is seen.
  task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] eQ, input logic [31:0] eR, input logic eDz,
                       input bit disturb, input string tag);
    int cnt;
    int busyCnt;
    bus.iStart    = 1'b1;
    bus.iDividend = a;
    bus.iDivisor  = b;
    bus.iSigned   = s;
    @(negedge iClk);
    bus.iStart    = 1'b0;
    bus.iDividend = $urandom;
    bus.iDivisor  = $urandom;
    bus.iSigned   = 1'($urandom_range(0, 1));
    cnt     = 0;
    busyCnt = 0;
    while (!bus.oDone && cnt < 100) begin
      if (bus.oBusy) busyCnt++;
      if (disturb && cnt == 5) begin
        bus.iStart    = 1'b1;
        bus.iDividend = $urandom;
        bus.iDivisor  = $urandom;
        bus.iSigned   = ~bus.iSigned;
      end
      if (cnt == 6) bus.iStart = 1'b0;
      @(negedge iClk);
      cnt++;
    end
    check({tag, " latency"},   32'(cnt),          eDz ? 32'd1 : 32'd33);
    check({tag, " busycyc"},   32'(busyCnt),      eDz ? 32'd1 : 32'd33);
    check({tag, " quotient"},  bus.oQuotient,     eQ);
    check({tag, " remainder"}, bus.oRemainder,    eR);
    check({tag, " divzero"},   32'(bus.oDivZero), 32'(eDz));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, q, r;
    logic        s, dz;

    iRst          = 1'b1;
    bus.iStart    = 1'b0;
    bus.iSigned   = 1'b0;
    bus.iDividend = '0;
    bus.iDivisor  = '0;
    repeat (3) @(negedge iClk);
    check("reset quotient",  bus.oQuotient,  32'd0);
    check("reset remainder", bus.oRemainder, 32'd0);
    check("reset busy",      32'(bus.oBusy), 32'd0);
    check("reset done",      32'(bus.oDone), 32'd0);
    iRst = 1'b0;
    @(negedge iClk);

    runOp(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b0, "u100/7");
    repeat (3) begin
      @(negedge iClk);
      check("hold quotient",  bus.oQuotient,  32'd14);
      check("hold remainder", bus.oRemainder, 32'd2);
      check("hold done",      32'(bus.oDone), 32'd0);
    end

    runOp(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b1, "s-7/2");
    runOp(32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, 1'b0, 1'b0, "uFFFFFFF9/2");
    runOp(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 1'b0, "sovf");
    runOp(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, "uMax/1");
    @(negedge iClk);
    runOp(32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, 1'b1, 1'b0, "u5/0");
    runOp(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, "u9/3");

    // Abort with reset partway through the iteration.
    bus.iStart    = 1'b1;
    bus.iDividend = 32'd1000;
    bus.iDivisor  = 32'd3;
    bus.iSigned   = 1'b0;
    @(negedge iClk);
    bus.iStart = 1'b0;
    repeat (9) @(negedge iClk);
    iRst = 1'b1;
    @(negedge iClk);
    check("abort quotient",  bus.oQuotient,     32'd0);
    check("abort remainder", bus.oRemainder,    32'd0);
    check("abort busy",      32'(bus.oBusy),    32'd0);
    check("abort done",      32'(bus.oDone),    32'd0);
    check("abort divzero",   32'(bus.oDivZero), 32'd0);
    iRst = 1'b0;
    repeat (40) begin
      @(negedge iClk);
      check("abort nodone", 32'(bus.oDone), 32'd0);
    end

    runOp(32'd20, 32'd6, 1'b0, 32'd3, 32'd2, 1'b0, 1'b0, "u20/6");
    runOp(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0, "s7/-2");

    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      refDiv(a, b, s, q, r, dz);
      runOp(a, b, s, q, r, dz, (b != 32'd0) && ($urandom_range(0, 3) == 0), "rand");
      repeat ($urandom_range(0, 2)) @(negedge iClk);
    end

    repeat (2) @(negedge iClk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
